log_mag_pipe: RTL

- Pipelined, parametrised successor to the combinational log-magnitude calculator.
- Takes signed I/Q (x, y) samples and computes a fixed-point log2(x^2 + y^2), split into an integer part and FRAC_W fractional bits.
- Uses a valid/ready stream interface with full backpressure and sustains one sample per clock.
- Sits between the FFT output stage and the spectrum display/packer.

---
 rtl/log_mag_pipe.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/log_mag_pipe.sv
// log_mag_pipe
//   Pipelined fixed-point log2 magnitude calculator for signed I/Q samples.
//   Computes log2(x^2 + y^2) as {integer part, FRAC_W fractional bits}, where
//   the fraction is the FRAC_W mantissa bits directly below the leading one
//   (truncated). Four register stages, one sample per clock, full backpressure.
//
//   Optional feature macro: LOG_MAG_PEAK_HOLD_EN
//     Adds per-frame peak tracking of the transferred log_mag values.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   x/y valid
//   in_ready   out  sample accepted when in_valid && in_ready
//   x, y       in   signed IN_W-bit real/imaginary components
//   in_last    in   end-of-frame tag (LOG_MAG_PEAK_HOLD_EN only)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   peak_valid out  one-cycle frame-peak pulse (LOG_MAG_PEAK_HOLD_EN only)
//   peak_log   out  frame peak of log_mag (LOG_MAG_PEAK_HOLD_EN only)
//   log_mag    out  {integer log2, fraction}, unsigned
//   out_zero   out  magnitude squared was exactly zero
module log_mag_pipe #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 4,
  localparam int INT_W = $clog2(2*IN_W+1),
  localparam int OUT_W = INT_W + FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  x,
  input  logic signed [IN_W-1:0]  y,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef LOG_MAG_PEAK_HOLD_EN
  input  logic                    in_last,
  output logic                    peak_valid,
  output logic [OUT_W-1:0]        peak_log,
`endif
  output logic [OUT_W-1:0]        log_mag,
  output logic                    out_zero
);

  localparam int SQ_W = 2*IN_W;
  localparam int M    = 2*IN_W + 1;

  // Stage registers
  logic                    v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, v4_d, v4_q;
  logic [SQ_W-1:0]         sq_x_d, sq_x_q, sq_y_d, sq_y_q;
  logic [M-1:0]            mag2_d, mag2_q;
  logic [M-1:0]            mag3_d, mag3_q;
  logic [INT_W-1:0]        p3_d, p3_q;
  logic                    zero3_d, zero3_q;
  logic [OUT_W-1:0]        log4_d, log4_q;
  logic                    zero4_d, zero4_q;

  // Combinational helpers
  logic                    adv;
  logic signed [SQ_W-1:0]  x_ext, y_ext, prod_x, prod_y;
  logic [INT_W-1:0]        p_enc;
  logic [INT_W-1:0]        shamt;
  logic [M-1:0]            norm;
  logic [FRAC_W-1:0]       frac;

  // The whole pipeline moves as one unit: it advances whenever the output
  // register is empty or being drained this cycle.
  assign adv       = !v4_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v4_q;
  assign log_mag   = log4_q;
  assign out_zero  = zero4_q;

  // Squares are formed at full 2*IN_W width so that (-2^(IN_W-1))^2 is exact;
  // the result is never negative, so it is reinterpreted as unsigned.
  always_comb begin
    x_ext  = SQ_W'(x);
    y_ext  = SQ_W'(y);
    prod_x = x_ext * x_ext;
    prod_y = y_ext * y_ext;
  end

  // Leading-one detector: the highest set bit wins because it is visited last.
  always_comb begin
    p_enc = '0;
    for (int i = 0; i < M; i++) begin
      if (mag2_q[i]) p_enc = INT_W'(i);
    end
  end

  // Left-justify the magnitude so the leading one lands in bit M-1; the
  // fraction is then the fixed field just below it. Small magnitudes shift
  // zeros into that field.
  always_comb begin
    shamt = INT_W'(M-1) - p3_q;
    norm  = mag3_q << shamt;
    frac  = norm[M-2 -: FRAC_W];
  end

  // Next-state for every stage: hold by default, load when the pipe advances.
  always_comb begin
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    v4_d    = v4_q;
    sq_x_d  = sq_x_q;
    sq_y_d  = sq_y_q;
    mag2_d  = mag2_q;
    mag3_d  = mag3_q;
    p3_d    = p3_q;
    zero3_d = zero3_q;
    log4_d  = log4_q;
    zero4_d = zero4_q;
    if (adv) begin
      v1_d    = in_valid;
      sq_x_d  = $unsigned(prod_x);
      sq_y_d  = $unsigned(prod_y);
      v2_d    = v1_q;
      mag2_d  = {1'b0, sq_x_q} + {1'b0, sq_y_q};
      v3_d    = v2_q;
      mag3_d  = mag2_q;
      p3_d    = p_enc;
      zero3_d = (mag2_q == '0);
      v4_d    = v3_q;
      log4_d  = zero3_q ? '0 : {p3_q, frac};
      zero4_d = zero3_q;
    end
  end

  // Stage register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      sq_x_q  <= '0;
      sq_y_q  <= '0;
      mag2_q  <= '0;
      mag3_q  <= '0;
      p3_q    <= '0;
      zero3_q <= 1'b0;
      log4_q  <= '0;
      zero4_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      v4_q    <= v4_d;
      sq_x_q  <= sq_x_d;
      sq_y_q  <= sq_y_d;
      mag2_q  <= mag2_d;
      mag3_q  <= mag3_d;
      p3_q    <= p3_d;
      zero3_q <= zero3_d;
      log4_q  <= log4_d;
      zero4_q <= zero4_d;
    end
  end

`ifdef LOG_MAG_PEAK_HOLD_EN
  logic             l1_d, l1_q, l2_d, l2_q, l3_d, l3_q, l4_d, l4_q;
  logic [OUT_W-1:0] peak_run_d, peak_run_q;
  logic [OUT_W-1:0] peak_log_d, peak_log_q;
  logic             peak_valid_d, peak_valid_q;
  logic [OUT_W-1:0] peak_max;
  logic             out_xfer;

  assign peak_valid = peak_valid_q;
  assign peak_log   = peak_log_q;
  assign out_xfer   = v4_q && out_ready;

  // The frame tag rides alongside its sample; running max covers only beats
  // actually transferred. Zero-magnitude beats already carry log_mag = 0.
  always_comb begin
    l1_d         = l1_q;
    l2_d         = l2_q;
    l3_d         = l3_q;
    l4_d         = l4_q;
    peak_run_d   = peak_run_q;
    peak_log_d   = peak_log_q;
    peak_valid_d = 1'b0;
    peak_max     = (log4_q > peak_run_q) ? log4_q : peak_run_q;
    if (adv) begin
      l1_d = in_last;
      l2_d = l1_q;
      l3_d = l2_q;
      l4_d = l3_q;
    end
    if (out_xfer) begin
      if (l4_q) begin
        peak_log_d   = peak_max;
        peak_valid_d = 1'b1;
        peak_run_d   = '0;
      end else begin
        peak_run_d   = peak_max;
      end
    end
  end

  // Peak tracker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      l1_q         <= 1'b0;
      l2_q         <= 1'b0;
      l3_q         <= 1'b0;
      l4_q         <= 1'b0;
      peak_run_q   <= '0;
      peak_log_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      l1_q         <= l1_d;
      l2_q         <= l2_d;
      l3_q         <= l3_d;
      l4_q         <= l4_d;
      peak_run_q   <= peak_run_d;
      peak_log_q   <= peak_log_d;
      peak_valid_q <= peak_valid_d;
    end
  end
`endif

endmodule
